// File: rtl/i2c_target.sv
// I2C target with a fixed 7-bit address: write bytes leave on rx_valid_o,
// read bytes are fetched from the local side with a tx_req_o pulse.
`timescale 1ns/1ps
module i2c_target #(
    parameter logic [6:0] SLV_ADDR = 7'h48
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    output logic       tx_req_o,
    output logic       busy_o
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] sr, sr_nxt;
    logic [7:0] rx_data_nxt;
    logic       oe_nxt, busy_nxt, rx_valid_nxt;

    // [1:0] is the synchronizer, [2] the history sample used for edge detection
    logic [2:0] scl_sh, sda_sh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sh <= '1;
            sda_sh <= '1;
        end else begin
            scl_sh <= {scl_sh[1:0], scl_i};
            sda_sh <= {sda_sh[1:0], sda_i};
        end
    end

    logic scl_s, scl_h, sda_s, sda_h;
    logic scl_rise, scl_fall, bus_start, bus_stop;
    assign scl_s     = scl_sh[1];
    assign scl_h     = scl_sh[2];
    assign sda_s     = sda_sh[1];
    assign sda_h     = sda_sh[2];
    assign scl_rise  = scl_s & ~scl_h;
    assign scl_fall  = ~scl_s & scl_h;
    assign bus_start = scl_s & scl_h & sda_h & ~sda_s;
    assign bus_stop  = scl_s & scl_h & ~sda_h & sda_s;

    logic [7:0] sr_shift;
    logic       addr_hit;
    assign sr_shift = {sr[6:0], sda_s};
    assign addr_hit = (sr_shift[7:1] == SLV_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            sda_oe_o   <= 1'b0;
            busy_o     <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sr         <= sr_nxt;
            sda_oe_o   <= oe_nxt;
            busy_o     <= busy_nxt;
            rx_data_o  <= rx_data_nxt;
            rx_valid_o <= rx_valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus_start) begin
            state_nxt = ADDR;
        end else if (bus_stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && cnt == 4'd7 && !addr_hit) state_nxt = WAIT;
                    else if (scl_fall && cnt == 4'd8)         state_nxt = ADDR_ACK;
                end
                ADDR_ACK: if (scl_fall) state_nxt = sr[0] ? RD_DATA : WR_DATA;
                WR_DATA:  if (scl_fall && cnt == 4'd8) state_nxt = WR_ACK;
                WR_ACK:   if (scl_fall) state_nxt = WR_DATA;
                RD_DATA:  if (scl_fall && cnt == 4'd7) state_nxt = RD_ACK;
                // a fall in RD_ACK can only follow a rise that saw ACK
                RD_ACK: begin
                    if (scl_rise && sda_s) state_nxt = WAIT;
                    else if (scl_fall)     state_nxt = RD_DATA;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_nxt      = cnt;
        sr_nxt       = sr;
        oe_nxt       = sda_oe_o;
        busy_nxt     = busy_o;
        rx_data_nxt  = rx_data_o;
        rx_valid_nxt = 1'b0;
        tx_req_o     = 1'b0;
        if (bus_start) begin
            cnt_nxt = '0;
            oe_nxt  = 1'b0;
        end else if (bus_stop) begin
            oe_nxt   = 1'b0;
            busy_nxt = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && cnt < 4'd8) begin
                        sr_nxt  = sr_shift;
                        cnt_nxt = cnt + 4'd1;
                        if (cnt == 4'd7 && !addr_hit) busy_nxt = 1'b0;
                    end else if (scl_fall && cnt == 4'd8) begin
                        oe_nxt   = 1'b1;
                        busy_nxt = 1'b1;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_nxt = '0;
                        if (sr[0]) begin
                            tx_req_o = 1'b1;
                            sr_nxt   = tx_data_i;
                            oe_nxt   = ~tx_data_i[7];
                        end else begin
                            oe_nxt = 1'b0;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise && cnt < 4'd8) begin
                        sr_nxt  = sr_shift;
                        cnt_nxt = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            rx_data_nxt  = sr_shift;
                            rx_valid_nxt = 1'b1;
                        end
                    end else if (scl_fall && cnt == 4'd8) begin
                        oe_nxt = 1'b1;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        oe_nxt  = 1'b0;
                        cnt_nxt = '0;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt == 4'd7) begin
                            oe_nxt  = 1'b0;
                            cnt_nxt = '0;
                        end else begin
                            sr_nxt  = {sr[6:0], 1'b0};
                            oe_nxt  = ~sr[6];
                            cnt_nxt = cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_s) begin
                        busy_nxt = 1'b0;
                    end else if (scl_fall) begin
                        tx_req_o = 1'b1;
                        sr_nxt   = tx_data_i;
                        oe_nxt   = ~tx_data_i[7];
                        cnt_nxt  = '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged bus master, transaction-level expectations.
`timescale 1ns/1ps
module tb_i2c_target;
    localparam int Q = 6;  // clk cycles per quarter SCL period
    localparam logic [6:0] ADDR = 7'h48;

    logic       clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, rx_valid, tx_req, busy, sda_bus;
    logic [7:0] rx_data;

    int n_chk = 0, n_fail = 0;
    int n_rx = 0, n_req = 0, n_oe = 0, n_viol = 0, scl_hi = 0;
    logic       oe_prev = 1'b0;
    logic [7:0] rx_log [0:255];
    logic [7:0] pd [0:15];

    assign sda_bus = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    i2c_target #(.SLV_ADDR(ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus),
        .sda_oe_o(sda_oe), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .tx_data_i(tx_data), .tx_req_o(tx_req), .busy_o(busy)
    );

    // bus monitor: log strobes and flag SDA moving while SCL is held high
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[n_rx % 256] = rx_data;
            n_rx++;
        end
        if (tx_req) n_req++;
        if (sda_oe) n_oe++;
        if (rst_n && scl_m && scl_hi >= 1 && sda_oe != oe_prev) n_viol++;
        scl_hi  = scl_m ? scl_hi + 1 : 0;
        oe_prev = sda_oe;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic qw();
        repeat (Q) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); sda_m = 1'b0; qw(); scl_m = 1'b0; qw();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qw(); scl_m = 1'b1; qw(); sda_m = 1'b1; qw(); qw();
    endtask

    task automatic wbits(input logic [7:0] b, input int nb);
        for (int i = 7; i > 7 - nb; i--) begin
            sda_m = b[i]; qw(); scl_m = 1'b1; qw(); qw(); scl_m = 1'b0; qw();
        end
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        wbits(b, 8);
        sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); ack = sda_bus; qw(); scl_m = 1'b0; qw();
    endtask

    task automatic rbyte(input logic mack, output logic [7:0] b);
        sda_m = 1'b1;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            qw(); scl_m = 1'b1; qw(); b = {b[6:0], sda_bus}; qw(); scl_m = 1'b0;
        end
        qw(); sda_m = ~mack; qw(); scl_m = 1'b1; qw(); qw(); scl_m = 1'b0; qw();
    endtask

    // a matched address ACKs every byte and delivers pd[] in order; otherwise silence
    task automatic wr_txn(input logic [6:0] a, input int n, input bit do_stop);
        logic ack;
        int base, oe0;
        bit m;
        base = n_rx; oe0 = n_oe; m = (a == ADDR);
        bus_start();
        wbyte({a, 1'b0}, ack);
        chk("wr_addr_ack", 32'(ack), 32'(!m));
        chk("busy_addr", 32'(busy), 32'(m));
        for (int i = 0; i < n; i++) begin
            wbyte(pd[i], ack);
            chk("wr_data_ack", 32'(ack), 32'(!m));
        end
        chk("rx_count", n_rx - base, m ? n : 0);
        if (m) for (int i = 0; i < n; i++) chk("rx_byte", 32'(rx_log[(base + i) % 256]), 32'(pd[i]));
        else chk("mismatch_no_drive", n_oe - oe0, 0);
        if (do_stop) begin
            bus_stop();
            chk("busy_stop", 32'(busy), 0);
            chk("oe_stop", 32'(sda_oe), 0);
        end
    endtask

    // master reads n bytes, ACKing all but the last; target returns pd[] in order
    task automatic rd_txn(input logic [6:0] a, input int n);
        logic ack;
        logic [7:0] b;
        int req0, oe0;
        bit m;
        req0 = n_req; oe0 = n_oe; m = (a == ADDR);
        tx_data = pd[0];
        bus_start();
        wbyte({a, 1'b1}, ack);
        chk("rd_addr_ack", 32'(ack), 32'(!m));
        chk("busy_addr", 32'(busy), 32'(m));
        tx_data = pd[1];
        for (int i = 0; i < n; i++) begin
            rbyte(i != n - 1, b);
            chk("rd_byte", 32'(b), m ? 32'(pd[i]) : 32'hFF);
            tx_data = pd[(i + 2) % 16];
        end
        chk("busy_nack", 32'(busy), 0);
        if (!m) chk("mismatch_no_drive", n_oe - oe0, 0);
        bus_stop();
        chk("tx_req_count", n_req - req0, m ? n : 0);
        chk("oe_stop", 32'(sda_oe), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic ack;
        logic [6:0] a;
        int base, n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_oe", 32'(sda_oe), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_tx_req", 32'(tx_req), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        qw();

        pd[0] = 8'hA5; pd[1] = 8'h3C;
        wr_txn(ADDR, 2, 1'b1);

        pd[0] = 8'h11;
        wr_txn(7'h49, 1, 1'b1);

        pd[0] = 8'h96; pd[1] = 8'h0F; pd[2] = 8'hEE; pd[3] = 8'hEE;
        rd_txn(ADDR, 2);

        // repeated START from a write into a read
        pd[0] = 8'h01;
        wr_txn(ADDR, 1, 1'b0);
        pd[0] = 8'hC3; pd[1] = 8'h77; pd[2] = 8'h77;
        rd_txn(ADDR, 1);
        chk("rx_data_sr", 32'(rx_data), 32'h01);

        // STOP in the middle of a write byte
        bus_start();
        wbyte({ADDR, 1'b0}, ack);
        chk("partial_addr_ack", 32'(ack), 0);
        base = n_rx;
        wbits(8'hA7, 4);
        bus_stop();
        chk("partial_no_rx", n_rx - base, 0);
        chk("partial_busy", 32'(busy), 0);
        pd[0] = 8'h55;
        wr_txn(ADDR, 1, 1'b1);
        chk("rx_data_55", 32'(rx_data), 32'h55);

        // async reset while the target is driving the address ACK
        bus_start();
        wbits({ADDR, 1'b0}, 8);
        qw();
        chk("ack_driven", 32'(sda_oe), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oe", 32'(sda_oe), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rx_data", 32'(rx_data), 0);
        chk("arst_rx_valid", 32'(rx_valid), 0);
        chk("arst_tx_req", 32'(tx_req), 0);
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        bus_stop();
        pd[0] = 8'h5A; pd[1] = 8'hC7;
        wr_txn(ADDR, 2, 1'b1);

        for (int t = 0; t < 14; t++) begin
            a = ($urandom_range(0, 2) != 0) ? ADDR : 7'($urandom);
            n = $urandom_range(1, 3);
            for (int i = 0; i < 16; i++) pd[i] = 8'($urandom);
            if ($urandom_range(0, 1) != 0) rd_txn(a, n);
            else wr_txn(a, n, 1'b1);
        end

        chk("sda_stable_scl_high", n_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
I2C target (responder) with a 7-bit address, sampling SCL/SDA from the pins and pulling SDA low open-drain. It is the responder-side counterpart of the on-chip I2C read master. It is used to model or provide an I2C sensor/peripheral in simulation and FPGA builds. Received bytes go out on a byte-wide valid strobe; read bytes are fetched from the local side through a request pulse.

Parameters:
- SLV_ADDR, 7'h48, target address matched against the first byte after START.

Ports:
- clk  input  1  system clock; must run at least 20x the SCL rate.
- rst_n  input  1  asynchronous active-low reset.
- scl_i  input  1  SCL pin level (asynchronous).
- sda_i  input  1  SDA pin level (asynchronous).
- sda_oe_o  output  1  1 = pull SDA low; 0 = release. The pad is SDA = sda_oe_o ? 0 : z.
- rx_data_o  output  8  last byte written by the master.
- rx_valid_o  output  1  one-cycle pulse; rx_data_o is updated in the same cycle.
- tx_data_i  input  8  byte returned on the next read slot; sampled when tx_req_o pulses.
- tx_req_o  output  1  one-cycle pulse; tx_data_i is captured in this cycle.
- busy_o  output  1  high from an address match until STOP, NACK or mismatch.

Behaviour:
- Reset (async, rst_n=0): sda_oe_o=0, rx_data_o=0, rx_valid_o=0, tx_req_o=0, busy_o=0, state IDLE, bit counter=0.
- Input sync:
  - scl_i and sda_i each pass through 2 flops, plus 1 history flop, all reset to 1.
  - Edge detection uses the synced value against the history flop; bus reaction latency is 3 clk.
- Bus events:
  - SCL rise = synced scl 0->1; SCL fall = synced scl 1->0.
  - START = sda 1->0 while scl is 1 in both samples.
  - STOP = sda 0->1 while scl is 1 in both samples.
  - If SCL and SDA change in the same sample, no START/STOP is flagged.
- START in any state (including repeated START) -> ADDR, bit counter=0, sda_oe_o=0.
- STOP in any state -> IDLE, sda_oe_o=0, busy_o=0. START/STOP take priority over SCL edges.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT.
- IDLE: ignore SCL edges; wait for START.
- ADDR:
  - Shift sda MSB-first on each SCL rise.
  - On the 8th rise, compare bits[7:1] with SLV_ADDR; bit0 is R/W (1 = read).
  - Match: on the next SCL fall, sda_oe_o=1, busy_o=1, go to ADDR_ACK.
  - Mismatch: go to WAIT with SDA released.
- ADDR_ACK: on the SCL fall ending the 9th clock:
  - Write: sda_oe_o=0 -> WR_DATA.
  - Read: pulse tx_req_o, load tx_data_i into the shift register, sda_oe_o=~tx_data_i[7] -> RD_DATA.
- WR_DATA:
  - Shift on SCL rise.
  - On the 8th rise: rx_data_o=shifted byte and rx_valid_o pulses in the same cycle.
  - Next SCL fall: sda_oe_o=1 -> WR_ACK. Every write byte is ACKed.
- WR_ACK: on SCL fall, sda_oe_o=0, counter=0 -> WR_DATA.
- RD_DATA:
  - On each SCL fall, shift left and drive the next bit as sda_oe_o=~bit.
  - After the 8th bit's SCL fall, sda_oe_o=0 (release for master ACK) -> RD_ACK.
- RD_ACK: sample sda on SCL rise.
  - 0 (ACK): on the next SCL fall, pulse tx_req_o, load the byte, drive MSB -> RD_DATA.
  - 1 (NACK): busy_o=0 -> WAIT with SDA released.
- WAIT: SDA released; leave only on START (-> ADDR) or STOP (-> IDLE).
- Counters: the 4-bit bit counter clears on START and at each byte boundary; there is no wrap past 8.
- SDA never changes while synced SCL is high, except release on STOP or reset.
- Reset asserted mid-transfer releases SDA immediately, with no completion of the byte or ACK.

Test Plan:
- Write: START, 0x90, 0xA5, 0x3C, STOP.
  - ACK is low on all 3 ninth clocks.
  - rx_valid_o pulses twice with rx_data_o=0xA5 then 0x3C; busy_o returns to 0 after STOP.
- Mismatch: START, 0x92, 0x11, STOP.
  - sda_oe_o stays 0 throughout; no rx_valid_o pulse; busy_o stays 0.
- Read: START, 0x91; tx_data_i=0x96 then 0x0F; master ACKs byte 1 and NACKs byte 2; STOP.
  - Master samples 0x96 and 0x0F; tx_req_o pulses exactly twice.
  - After the NACK, SDA is released and no third tx_req_o occurs.
- Repeated START: START, 0x90, 0x01, Sr, 0x91, read 1 byte with tx_data_i=0xC3, NACK, STOP.
  - rx_data_o=0x01; master reads 0xC3; state passes ADDR -> ADDR_ACK -> RD_DATA.
- STOP after 4 bits of a write byte.
  - No rx_valid_o pulse; IDLE with busy_o=0.
  - A following START, 0x90, 0x55 yields rx_data_o=0x55.
- rst_n low while sda_oe_o=1 in ADDR_ACK.
  - sda_oe_o=0 asynchronously and all outputs go to their reset values.
  - The next full write transaction completes normally.
